// File: rtl/ase_mmio_rsp_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ase_mmio_rsp_tracker_pkg
// Shared ASE definitions for the MMIO read-response tracker:
//   - sizing constants (outstanding reads, response timeout, field widths)
//   - MMIORsp_t : one buffered MMIO read response {tid, data}
//   - timer_state_e : states of the oldest-pending-read age timer
//   - tid_onehot / age_sat_inc helper functions
// ---------------------------------------------------------------------------
package ase_mmio_rsp_tracker_pkg;

    localparam int MMIO_MAX_OUTSTANDING = 64;
    localparam int MMIO_RSP_TIMEOUT     = 512;

    localparam int MMIO_TID_W     = 9;
    localparam int MMIO_TID_SPACE = 512;
    localparam int MMIO_DATA_W    = 64;
    // Wide enough to hold 0..MMIO_MAX_OUTSTANDING inclusive.
    localparam int MMIO_CNT_W     = 7;
    localparam int MMIO_AGE_W     = 10;

    typedef struct packed {
        logic [MMIO_TID_W-1:0]  tid;
        logic [MMIO_DATA_W-1:0] data;
    } MMIORsp_t;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_e;

    // One-hot mask selecting a single tid in the pending vector.
    function automatic logic [MMIO_TID_SPACE-1:0] tid_onehot(input logic [MMIO_TID_W-1:0] tid);
        logic [MMIO_TID_SPACE-1:0] mask;
        mask      = {MMIO_TID_SPACE{1'b0}};
        mask[tid] = 1'b1;
        return mask;
    endfunction

    // Age counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [MMIO_AGE_W-1:0] age_sat_inc(input logic [MMIO_AGE_W-1:0] age);
        logic [MMIO_AGE_W-1:0] nxt;
        if (age == {MMIO_AGE_W{1'b1}}) begin
            nxt = age;
        end else begin
            nxt = age + MMIO_AGE_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ase_mmio_rsp_tracker_fifo.sv
// ---------------------------------------------------------------------------
// ase_fifo
// Synchronous single-clock FIFO with first-word fall-through head.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i : write strobe and data; ignored while full
//   pop_i         : consume the head entry; ignored while empty
//   head_o        : current head entry (valid while empty_o is low)
//   empty_o       : no entries stored
//   count_o       : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module ase_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i && (count_q != CNT_FULL);
    assign pop_ok_s  = pop_i && (count_q != {CNT_W{1'b0}});

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;

endmodule

// File: rtl/ase_mmio_rsp_tracker.sv
// ---------------------------------------------------------------------------
// ase_mmio_rsp_tracker
// Tracks MMIO read requests issued by the ASE against responses returned by
// the AFU, buffers matched responses for the DPI drain in arrival order and
// flags timeouts, unexpected responses and duplicate tids.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_tid/req_ready : MMIO read request issue handshake
//   rsp_valid/rsp_tid/rsp_data  : AFU read response (no back-pressure)
//   out_valid/out_tid/out_data/out_ready : buffered response to the drain
//   pending_count            : number of tids awaiting a response
//   err_timeout/err_unexpected/err_dup_tid : one-cycle error pulses
//   err_tid                  : tid of the most recent error, held between errors
// ---------------------------------------------------------------------------
module ase_mmio_rsp_tracker
    import ase_mmio_rsp_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MMIO_MAX_OUTSTANDING,
    parameter int TIMEOUT_CYCLES  = MMIO_RSP_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [MMIO_TID_W-1:0]  req_tid,
    output logic                   req_ready,
    input  logic                   rsp_valid,
    input  logic [MMIO_TID_W-1:0]  rsp_tid,
    input  logic [MMIO_DATA_W-1:0] rsp_data,
    output logic                   out_valid,
    output logic [MMIO_TID_W-1:0]  out_tid,
    output logic [MMIO_DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic [MMIO_CNT_W-1:0]  pending_count,
    output logic                   err_timeout,
    output logic                   err_unexpected,
    output logic                   err_dup_tid,
    output logic [MMIO_TID_W-1:0]  err_tid
);

    localparam logic [MMIO_CNT_W:0]   MAX_OCC   = MAX_OUTSTANDING[MMIO_CNT_W:0];
    localparam logic [MMIO_AGE_W-1:0] AGE_LIMIT = MMIO_AGE_W'(TIMEOUT_CYCLES - 1);

    logic [MMIO_TID_SPACE-1:0] pending_q, pending_d;
    logic [MMIO_CNT_W-1:0]     pend_cnt_q, pend_cnt_d;

    logic [MMIO_CNT_W-1:0]     ordq_cnt_s;
    logic [MMIO_CNT_W-1:0]     rsp_cnt_s;
    logic                      ordq_empty_s;
    logic                      rsp_empty_s;
    logic [MMIO_TID_W-1:0]     ordq_head_s;
    MMIORsp_t                  rsp_in_s;
    MMIORsp_t                  rsp_head_s;

    logic [MMIO_CNT_W:0]       occ_s;
    logic                      req_ready_s;
    logic                      req_fire_s;
    logic                      req_new_s;
    logic                      req_dup_s;
    logic                      rsp_hit_s;
    logic                      rsp_miss_s;
    logic                      out_pop_s;

    timer_state_e              state_q, state_d;
    logic [MMIO_AGE_W-1:0]     age_q, age_d;
    logic                      ordq_pop_s;
    logic                      ordq_last_s;
    logic                      head_pending_s;
    logic                      tmo_fire_s;

    logic                      err_timeout_q;
    logic                      err_unexp_q;
    logic                      err_dup_q;
    logic [MMIO_TID_W-1:0]     err_tid_q, err_tid_d;

    // Reads in flight plus responses still buffered share one budget.
    assign occ_s       = {1'b0, pend_cnt_q} + {1'b0, rsp_cnt_s};
    assign req_ready_s = (occ_s < MAX_OCC);
    assign req_fire_s  = req_valid && req_ready_s;

    // Both request and response classify against the pre-cycle pending vector,
    // so a same-tid request/response pair never sets and clears the same bit.
    assign req_new_s  = req_fire_s && !pending_q[req_tid];
    assign req_dup_s  = req_fire_s &&  pending_q[req_tid];
    assign rsp_hit_s  = rsp_valid  &&  pending_q[rsp_tid];
    assign rsp_miss_s = rsp_valid  && !pending_q[rsp_tid];
    assign out_pop_s  = !rsp_empty_s && out_ready;

    assign pending_d = (pending_q | (req_new_s ? tid_onehot(req_tid) : {MMIO_TID_SPACE{1'b0}}))
                     & ~(rsp_hit_s ? tid_onehot(rsp_tid) : {MMIO_TID_SPACE{1'b0}});

    // Pending count follows new requests and matched responses.
    always_comb begin
        case ({req_new_s, rsp_hit_s})
            2'b10:   pend_cnt_d = pend_cnt_q + MMIO_CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - MMIO_CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    // Issue-order queue of tids. The occupancy budget bounds live tids, but
    // answered tids stay queued behind a still-pending head until the timer
    // pops them; if that ever fills the queue, the newest tid is simply not
    // age-tracked.
    ase_fifo #(
        .WIDTH (MMIO_TID_W),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (MMIO_CNT_W)
    ) u_ordq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (req_new_s),
        .push_data_i (req_tid),
        .pop_i       (ordq_pop_s),
        .head_o      (ordq_head_s),
        .empty_o     (ordq_empty_s),
        .count_o     (ordq_cnt_s)
    );

    assign rsp_in_s = '{tid: rsp_tid, data: rsp_data};

    // Matched responses in arrival order; cannot overflow because every entry
    // was counted against the occupancy budget while it was pending.
    ase_fifo #(
        .WIDTH ($bits(MMIORsp_t)),
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (MMIO_CNT_W)
    ) u_rspq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_hit_s),
        .push_data_i (rsp_in_s),
        .pop_i       (out_pop_s),
        .head_o      (rsp_head_s),
        .empty_o     (rsp_empty_s),
        .count_o     (rsp_cnt_s)
    );

    assign head_pending_s = pending_q[ordq_head_s];
    // Popping the only queued tid empties the queue unless one is pushed now.
    assign ordq_last_s    = (ordq_cnt_s == MMIO_CNT_W'(1)) && !req_new_s;

    // Timer next-state: ages the oldest pending tid and retires answered heads.
    always_comb begin
        state_d    = state_q;
        age_d      = age_q;
        ordq_pop_s = 1'b0;
        tmo_fire_s = 1'b0;
        case (state_q)
            T_IDLE: begin
                // Start on the push itself so the age is counted from acceptance.
                if (req_new_s || !ordq_empty_s) begin
                    state_d = T_COUNT;
                    age_d   = {MMIO_AGE_W{1'b0}};
                end else begin
                    state_d = T_IDLE;
                end
            end
            T_COUNT: begin
                if (ordq_empty_s) begin
                    state_d = T_IDLE;
                    age_d   = {MMIO_AGE_W{1'b0}};
                end else if (!head_pending_s) begin
                    ordq_pop_s = 1'b1;
                    age_d      = {MMIO_AGE_W{1'b0}};
                    state_d    = ordq_last_s ? T_IDLE : T_COUNT;
                end else if (age_q == AGE_LIMIT) begin
                    state_d    = T_EXPIRED;
                    tmo_fire_s = 1'b1;
                end else begin
                    age_d = age_sat_inc(age_q);
                end
            end
            T_EXPIRED: begin
                if (ordq_empty_s) begin
                    state_d = T_IDLE;
                    age_d   = {MMIO_AGE_W{1'b0}};
                end else if (!head_pending_s) begin
                    ordq_pop_s = 1'b1;
                    age_d      = {MMIO_AGE_W{1'b0}};
                    state_d    = ordq_last_s ? T_IDLE : T_COUNT;
                end else begin
                    state_d = T_EXPIRED;
                end
            end
            default: begin
                state_d = T_IDLE;
                age_d   = {MMIO_AGE_W{1'b0}};
            end
        endcase
    end

    // Error tid selection: timeout outranks unexpected, which outranks dup.
    always_comb begin
        if (tmo_fire_s) begin
            err_tid_d = ordq_head_s;
        end else if (rsp_miss_s) begin
            err_tid_d = rsp_tid;
        end else if (req_dup_s) begin
            err_tid_d = req_tid;
        end else begin
            err_tid_d = err_tid_q;
        end
    end

    // Tracker state, timer and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= {MMIO_TID_SPACE{1'b0}};
            pend_cnt_q    <= {MMIO_CNT_W{1'b0}};
            state_q       <= T_IDLE;
            age_q         <= {MMIO_AGE_W{1'b0}};
            err_timeout_q <= 1'b0;
            err_unexp_q   <= 1'b0;
            err_dup_q     <= 1'b0;
            err_tid_q     <= {MMIO_TID_W{1'b0}};
        end else begin
            pending_q     <= pending_d;
            pend_cnt_q    <= pend_cnt_d;
            state_q       <= state_d;
            age_q         <= age_d;
            err_timeout_q <= tmo_fire_s;
            err_unexp_q   <= rsp_miss_s;
            err_dup_q     <= req_dup_s;
            err_tid_q     <= err_tid_d;
        end
    end

    assign req_ready      = req_ready_s;
    assign out_valid      = !rsp_empty_s;
    // Storage is not reset, so the head is masked to zero while empty.
    assign out_tid        = rsp_empty_s ? {MMIO_TID_W{1'b0}}  : rsp_head_s.tid;
    assign out_data       = rsp_empty_s ? {MMIO_DATA_W{1'b0}} : rsp_head_s.data;
    assign pending_count  = pend_cnt_q;
    assign err_timeout    = err_timeout_q;
    assign err_unexpected = err_unexp_q;
    assign err_dup_tid    = err_dup_q;
    assign err_tid        = err_tid_q;

endmodule

// File: tb/tb_ase_mmio_rsp_tracker.sv
// ---------------------------------------------------------------------------
// tb_ase_mmio_rsp_tracker
// Directed scenarios plus a randomized run checked against a queue-based
// reference model of the tracker's request/response bookkeeping.
// ---------------------------------------------------------------------------
module tb_ase_mmio_rsp_tracker;
    import ase_mmio_rsp_tracker_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [8:0]  req_tid;
    logic        req_ready;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        out_valid;
    logic [8:0]  out_tid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [6:0]  pending_count;
    logic        err_timeout;
    logic        err_unexpected;
    logic        err_dup_tid;
    logic [8:0]  err_tid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_pend [512];
    int          m_pcnt;
    logic [8:0]  m_oq_tid [$];
    logic [63:0] m_oq_data [$];
    bit          m_unexp;
    bit          m_dup;
    logic [8:0]  m_tid;

    ase_mmio_rsp_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_tid        (req_tid),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_tid        (rsp_tid),
        .rsp_data       (rsp_data),
        .out_valid      (out_valid),
        .out_tid        (out_tid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .pending_count  (pending_count),
        .err_timeout    (err_timeout),
        .err_unexpected (err_unexpected),
        .err_dup_tid    (err_dup_tid),
        .err_tid        (err_tid)
    );

    always #5 clk = ~clk;

    // Apply the current inputs to the model, then advance one clock and settle.
    task automatic cycle();
        bit acc, hit, miss, dup, newr, popo;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_pcnt = 0;
            m_oq_tid.delete();
            m_oq_data.delete();
            m_unexp = 1'b0;
            m_dup   = 1'b0;
            m_tid   = 9'h000;
        end else begin
            acc  = req_valid && ((m_pcnt + m_oq_tid.size()) < 64);
            popo = out_ready && (m_oq_tid.size() > 0);
            hit  = rsp_valid &&  m_pend[rsp_tid];
            miss = rsp_valid && !m_pend[rsp_tid];
            dup  = acc &&  m_pend[req_tid];
            newr = acc && !m_pend[req_tid];
            if (popo) begin
                void'(m_oq_tid.pop_front());
                void'(m_oq_data.pop_front());
            end
            if (hit) begin
                m_oq_tid.push_back(rsp_tid);
                m_oq_data.push_back(rsp_data);
                m_pend[rsp_tid] = 1'b0;
                m_pcnt--;
            end
            if (newr) begin
                m_pend[req_tid] = 1'b1;
                m_pcnt++;
            end
            m_unexp = miss;
            m_dup   = dup;
            if (miss) m_tid = rsp_tid;
            else if (dup) m_tid = req_tid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_tid = 9'h000;
        rsp_valid = 1'b0; rsp_tid = 9'h000; rsp_data = 64'h0;
    endtask

    task automatic test_reset();
        idle_inputs(); out_ready = 1'b0; rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got %0h exp 1", req_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        n_checks++; if (out_tid !== 9'h000) begin n_errors++; $display("FAIL reset_out_tid got %0h exp 0", out_tid); end
        n_checks++; if (out_data !== 64'h0) begin n_errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        n_checks++; if (pending_count !== 7'd0) begin n_errors++; $display("FAIL reset_pending got %0d exp 0", pending_count); end
        n_checks++; if ({err_timeout, err_unexpected, err_dup_tid} !== 3'b000) begin n_errors++; $display("FAIL reset_errs got %b exp 000", {err_timeout, err_unexpected, err_dup_tid}); end
        n_checks++; if (err_tid !== 9'h000) begin n_errors++; $display("FAIL reset_err_tid got %0h exp 0", err_tid); end
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_tid = 9'h005;
        cycle();
        idle_inputs();
        n_checks++; if (pending_count !== 7'd1) begin n_errors++; $display("FAIL single_pend1 got %0d exp 1", pending_count); end
        repeat (9) cycle();
        rsp_valid = 1'b1; rsp_tid = 9'h005; rsp_data = 64'hDEADBEEF_CAFEF00D;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid got %0h exp 0", out_valid); end
        cycle();
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_out_valid got %0h exp 1", out_valid); end
        n_checks++; if (out_tid !== 9'h005) begin n_errors++; $display("FAIL single_out_tid got %0h exp 5", out_tid); end
        n_checks++; if (out_data !== 64'hDEADBEEF_CAFEF00D) begin n_errors++; $display("FAIL single_out_data got %0h exp deadbeefcafef00d", out_data); end
        n_checks++; if (pending_count !== 7'd0) begin n_errors++; $display("FAIL single_pend0 got %0d exp 0", pending_count); end
        n_checks++; if ({err_timeout, err_unexpected, err_dup_tid} !== 3'b000) begin n_errors++; $display("FAIL single_errs got %b exp 000", {err_timeout, err_unexpected, err_dup_tid}); end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_reorder();
        logic [8:0] exp_order [3];
        exp_order[0] = 9'd3; exp_order[1] = 9'd1; exp_order[2] = 9'd2;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_tid = 9'(i); cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            rsp_valid = 1'b1; rsp_tid = exp_order[i]; rsp_data = 64'h1000 + 64'(exp_order[i]); cycle();
        end
        idle_inputs();
        // Held stable while the drain stalls.
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++; if (out_tid !== 9'd3 || out_data !== 64'h1003) begin n_errors++; $display("FAIL reorder_hold got %0h/%0h exp 3/1003", out_tid, out_data); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_tid !== exp_order[i]) begin n_errors++; $display("FAIL reorder_out%0d got %0h exp %0h", i, out_tid, exp_order[i]); end
            out_ready = 1'b1; cycle(); out_ready = 1'b0;
        end
        repeat (3) cycle();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reorder_empty got %0h exp 0", out_valid); end
        n_checks++; if (dut.state_q !== T_IDLE) begin n_errors++; $display("FAIL reorder_fsm_idle got %0d exp %0d", dut.state_q, T_IDLE); end
        n_checks++; if (dut.u_ordq.count_o !== 7'd0) begin n_errors++; $display("FAIL reorder_ordq got %0d exp 0", dut.u_ordq.count_o); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int at_k = -1;
        req_valid = 1'b1; req_tid = 9'h010; cycle(); idle_inputs();
        for (int k = 1; k <= 600; k++) begin
            cycle();
            if (err_timeout === 1'b1) begin
                pulses++;
                if (at_k < 0) at_k = k;
            end
        end
        n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL timeout_pulses got %0d exp 1", pulses); end
        n_checks++; if (at_k != 512) begin n_errors++; $display("FAIL timeout_cycle got %0d exp 512", at_k); end
        n_checks++; if (err_tid !== 9'h010) begin n_errors++; $display("FAIL timeout_err_tid got %0h exp 10", err_tid); end
        rsp_valid = 1'b1; rsp_tid = 9'h010; rsp_data = 64'h0BAD_0010; cycle(); idle_inputs();
        n_checks++; if (err_unexpected !== 1'b0) begin n_errors++; $display("FAIL timeout_late_unexp got %0h exp 0", err_unexpected); end
        n_checks++; if (out_valid !== 1'b1 || out_tid !== 9'h010) begin n_errors++; $display("FAIL timeout_late_out got %0h/%0h exp 1/10", out_valid, out_tid); end
        pulses = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (err_timeout === 1'b1 || err_unexpected === 1'b1) pulses++;
        end
        out_ready = 1'b0;
        n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL timeout_no_more_err got %0d exp 0", pulses); end
        n_checks++; if (dut.state_q !== T_IDLE) begin n_errors++; $display("FAIL timeout_fsm_idle got %0d exp %0d", dut.state_q, T_IDLE); end
    endtask

    task automatic test_unexpected();
        rsp_valid = 1'b1; rsp_tid = 9'h1FF; rsp_data = 64'h5555; cycle(); idle_inputs();
        n_checks++; if (err_unexpected !== 1'b1) begin n_errors++; $display("FAIL unexp_pulse got %0h exp 1", err_unexpected); end
        n_checks++; if (err_tid !== 9'h1FF) begin n_errors++; $display("FAIL unexp_err_tid got %0h exp 1ff", err_tid); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL unexp_out_valid got %0h exp 0", out_valid); end
        cycle();
        n_checks++; if (err_unexpected !== 1'b0) begin n_errors++; $display("FAIL unexp_one_cycle got %0h exp 0", err_unexpected); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL unexp_out_valid2 got %0h exp 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1; req_tid = 9'h040 + 9'(i); cycle();
        end
        idle_inputs();
        n_checks++; if (pending_count !== 7'd64) begin n_errors++; $display("FAIL full_pend got %0d exp 64", pending_count); end
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_pend got %0h exp 0", req_ready); end
        for (int i = 0; i < 64; i++) begin
            rsp_valid = 1'b1; rsp_tid = 9'h040 + 9'(i); rsp_data = 64'hA5A5_0000_0000_0000 | 64'(i); cycle();
        end
        idle_inputs();
        n_checks++; if (req_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready_buf got %0h exp 0", req_ready); end
        n_checks++; if (pending_count !== 7'd0) begin n_errors++; $display("FAIL full_pend0 got %0d exp 0", pending_count); end
        req_valid = 1'b1; req_tid = 9'h100; cycle(); idle_inputs();
        n_checks++; if (pending_count !== 7'd0) begin n_errors++; $display("FAIL full_refused got %0d exp 0", pending_count); end
        n_checks++; if (out_tid !== 9'h040 || out_data !== 64'hA5A5_0000_0000_0000) begin n_errors++; $display("FAIL full_head got %0h/%0h exp 40/a5a5000000000000", out_tid, out_data); end
        out_ready = 1'b1; cycle(); out_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL full_ready_back got %0h exp 1", req_ready); end
        for (int i = 1; i < 64; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_tid !== 9'h040 + 9'(i)) begin n_errors++; $display("FAIL full_order%0d got %0h exp %0h", i, out_tid, 9'h040 + 9'(i)); end
            out_ready = 1'b1; cycle(); out_ready = 1'b0;
        end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL full_drained got %0h exp 0", out_valid); end
    endtask

    task automatic test_dup_reset();
        req_valid = 1'b1; req_tid = 9'd7; cycle();
        cycle();
        idle_inputs();
        n_checks++; if (err_dup_tid !== 1'b1) begin n_errors++; $display("FAIL dup_pulse got %0h exp 1", err_dup_tid); end
        n_checks++; if (err_tid !== 9'd7) begin n_errors++; $display("FAIL dup_err_tid got %0h exp 7", err_tid); end
        n_checks++; if (pending_count !== 7'd1) begin n_errors++; $display("FAIL dup_pend got %0d exp 1", pending_count); end
        req_valid = 1'b1; req_tid = 9'd8; cycle(); idle_inputs();
        rsp_valid = 1'b1; rsp_tid = 9'd8; rsp_data = 64'h88; cycle(); idle_inputs();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL dup_buffered got %0h exp 1", out_valid); end
        rst = 1'b1; cycle(); rst = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || out_valid !== 1'b0 || out_tid !== 9'h0 || out_data !== 64'h0) begin n_errors++; $display("FAIL midrst_outputs got %0h/%0h/%0h/%0h exp 1/0/0/0", req_ready, out_valid, out_tid, out_data); end
        n_checks++; if (pending_count !== 7'd0) begin n_errors++; $display("FAIL midrst_pend got %0d exp 0", pending_count); end
        n_checks++; if ({err_timeout, err_unexpected, err_dup_tid} !== 3'b000 || err_tid !== 9'h0) begin n_errors++; $display("FAIL midrst_errs got %b/%0h exp 000/0", {err_timeout, err_unexpected, err_dup_tid}, err_tid); end
        rsp_valid = 1'b1; rsp_tid = 9'd7; rsp_data = 64'h77; cycle(); idle_inputs();
        n_checks++; if (err_unexpected !== 1'b1 || err_tid !== 9'd7) begin n_errors++; $display("FAIL midrst_late_rsp got %0h/%0h exp 1/7", err_unexpected, err_tid); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_late_out got %0h exp 0", out_valid); end
    endtask

    task automatic test_random();
        idle_inputs(); out_ready = 1'b0; rst = 1'b1;
        cycle(); rst = 1'b0;
        // Short enough after reset that no timeout can legally occur.
        for (int c = 0; c < 350; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_tid   = 9'($urandom_range(0, 15));
            rsp_valid = 1'($urandom_range(0, 1));
            rsp_tid   = ($urandom_range(0, 9) < 8) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
            rsp_data  = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 2) != 0);
            cycle();
            n_checks++; if (req_ready !== ((m_pcnt + m_oq_tid.size()) < 64)) begin n_errors++; $display("FAIL rnd_ready c%0d got %0h", c, req_ready); end
            n_checks++; if (pending_count !== 7'(m_pcnt)) begin n_errors++; $display("FAIL rnd_pend c%0d got %0d exp %0d", c, pending_count, m_pcnt); end
            n_checks++; if (out_valid !== (m_oq_tid.size() > 0)) begin n_errors++; $display("FAIL rnd_out_valid c%0d got %0h exp %0d", c, out_valid, m_oq_tid.size() > 0); end
            if (m_oq_tid.size() > 0) begin
                n_checks++; if (out_tid !== m_oq_tid[0] || out_data !== m_oq_data[0]) begin n_errors++; $display("FAIL rnd_out c%0d got %0h/%0h exp %0h/%0h", c, out_tid, out_data, m_oq_tid[0], m_oq_data[0]); end
            end
            n_checks++; if (err_unexpected !== m_unexp) begin n_errors++; $display("FAIL rnd_unexp c%0d got %0h exp %0h", c, err_unexpected, m_unexp); end
            n_checks++; if (err_dup_tid !== m_dup) begin n_errors++; $display("FAIL rnd_dup c%0d got %0h exp %0h", c, err_dup_tid, m_dup); end
            n_checks++; if (err_tid !== m_tid) begin n_errors++; $display("FAIL rnd_err_tid c%0d got %0h exp %0h", c, err_tid, m_tid); end
            n_checks++; if (err_timeout !== 1'b0) begin n_errors++; $display("FAIL rnd_timeout c%0d got %0h exp 0", c, err_timeout); end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_reorder();
        test_timeout();
        test_unexpected();
        test_full();
        test_dup_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
